nibble_accumulator: RTL and testbench

NIBBLE_ACCUMULATOR -- requirements
Module: nibble_accumulator

---
 rtl/nibble_accumulator_pkg.sv | 12 +
 rtl/eightbitadder.sv | 9 +
 rtl/nibble_accumulator.sv | 87 ++++++++
 tb/tb_nibble_accumulator.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_accumulator_pkg.sv
// Shared types and widths for the nibble accumulator.
package nibble_accumulator_pkg;
  localparam int ACC_W     = 8;
  localparam int NIB_W     = 4;
  localparam int COUNT_MAX = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/eightbitadder.sv
// 8-bit + 4-bit unsigned adder with carry out of bit 7.
module eightbitadder (
  input  logic [7:0] A,
  input  logic [3:0] B,
  output logic [7:0] S,
  output logic       Co
);
  assign {Co, S} = {1'b0, A} + {5'b0, B};
endmodule

// File: rtl/nibble_accumulator.sv
// Accumulates COUNT nibbles per frame into an 8-bit sum with sticky carry flag.
// Define NIBBLE_ACC_SAT_EN to saturate the sum at 8'hFF on carry-out instead of wrapping.
module nibble_accumulator
  import nibble_accumulator_pkg::*;
#(
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NIB_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);
  localparam logic [7:0] COUNT_L = COUNT[7:0];

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [ACC_W-1:0] sum;
  logic             co;
  logic             accept;

  eightbitadder u_add (
    .A  (acc_q),
    .B  (in_data),
    .S  (sum),
    .Co (co)
  );

  // Reset gates the handshake outputs combinationally so they read 0 for the whole rst cycle.
  assign in_ready  = !rst && (state_q != DONE);
  assign out_valid = !rst && (state_q == DONE);
  assign busy      = !rst && (state_q == ACC);
  assign out_sum   = out_valid ? acc_q : '0;
  assign out_ovf   = out_valid && ovf_q;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, ACC: begin
        if (accept) begin
`ifdef NIBBLE_ACC_SAT_EN
          acc_d = co ? 8'hFF : sum;
`else
          acc_d = sum;
`endif
          ovf_d   = ovf_q | co;
          cnt_d   = cnt_q + 8'd1;
          state_d = (cnt_d == COUNT_L) ? DONE : ACC;
        end
      end
      DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_nibble_accumulator.sv
// Directed bench: four instances (COUNT = 4, 20, 3, 1) share stimulus; each test checks one.
module tb_nibble_accumulator;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       out_ready = 1'b0;

  logic [3:0] in_ready, out_valid, out_ovf, busy;
  logic [7:0] out_sum [4];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nibble_accumulator #(.COUNT(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]), .in_data(in_data),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_sum(out_sum[0]), .out_ovf(out_ovf[0]),
    .busy(busy[0]));
  nibble_accumulator #(.COUNT(20)) u20 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]), .in_data(in_data),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_sum(out_sum[1]), .out_ovf(out_ovf[1]),
    .busy(busy[1]));
  nibble_accumulator #(.COUNT(3)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]), .in_data(in_data),
    .out_valid(out_valid[2]), .out_ready(out_ready), .out_sum(out_sum[2]), .out_ovf(out_ovf[2]),
    .busy(busy[2]));
  nibble_accumulator #(.COUNT(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[3]), .in_data(in_data),
    .out_valid(out_valid[3]), .out_ready(out_ready), .out_sum(out_sum[3]), .out_ovf(out_ovf[3]),
    .busy(busy[3]));

  // Drive inputs, take one rising edge, then settle 1 time unit before any sampling.
  task automatic cyc(input logic v, input logic [3:0] d, input logic r);
    in_valid = v; in_data = d; out_ready = r;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 4'd0, 1'b0);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(1'b1, 4'hF, 1'b0);
    cyc(1'b1, 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out_valid[i], out_ovf[i], busy[i], in_ready[i], out_sum[i]} !== 12'd0) begin
        failures++;
        $display("FAIL reset_outputs inst=%0d got v=%b ovf=%b busy=%b rdy=%b sum=%h want all 0",
                 i, out_valid[i], out_ovf[i], busy[i], in_ready[i], out_sum[i]);
      end
    end
    rst = 1'b0; #1;
    checks++;
    if (in_ready !== 4'hF) begin
      failures++; $display("FAIL ready_after_reset got %b want 1111", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [3:0] d;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      d = 4'(i);
      cyc(1'b1, d, 1'b0);
      checks++;
      if (out_valid[0] !== 1'b0 || busy[0] !== 1'b1 || out_sum[0] !== 8'h00) begin
        failures++;
        $display("FAIL basic_acc nib=%0d got v=%b busy=%b sum=%h want v=0 busy=1 sum=00",
                 i, out_valid[0], busy[0], out_sum[0]);
      end
    end
    cyc(1'b1, 4'd4, 1'b0);
    checks++;
    if (out_valid[0] !== 1'b1 || out_sum[0] !== 8'h0A || out_ovf[0] !== 1'b0 ||
        in_ready[0] !== 1'b0 || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL basic_done got v=%b sum=%h ovf=%b rdy=%b busy=%b want 1 0a 0 0 0",
               out_valid[0], out_sum[0], out_ovf[0], in_ready[0], busy[0]);
    end
    cyc(1'b0, 4'd0, 1'b1);
    checks++;
    if (out_valid[0] !== 1'b0 || out_sum[0] !== 8'h00 || in_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL basic_drain got v=%b sum=%h rdy=%b want 0 00 1",
               out_valid[0], out_sum[0], in_ready[0]);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_sum;
`ifdef NIBBLE_ACC_SAT_EN
    exp_sum = 8'hFF;
`else
    exp_sum = 8'h2C;
`endif
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1'b1, 4'hF, 1'b0);
    checks++;
    if (out_valid[1] !== 1'b1 || out_sum[1] !== exp_sum || out_ovf[1] !== 1'b1) begin
      failures++;
      $display("FAIL overflow got v=%b sum=%h ovf=%b want 1 %h 1",
               out_valid[1], out_sum[1], out_ovf[1], exp_sum);
    end
    cyc(1'b0, 4'd0, 1'b1);
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'd5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 4'hF, 1'b0);
      checks++;
      if (out_valid[0] !== 1'b1 || out_sum[0] !== 8'h14 || out_ovf[0] !== 1'b0 ||
          in_ready[0] !== 1'b0) begin
        failures++;
        $display("FAIL stall cyc=%0d got v=%b sum=%h ovf=%b rdy=%b want 1 14 0 0",
                 i, out_valid[0], out_sum[0], out_ovf[0], in_ready[0]);
      end
    end
    cyc(1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'd1, 1'b0);
    checks++;
    if (out_valid[0] !== 1'b1 || out_sum[0] !== 8'h04 || out_ovf[0] !== 1'b0) begin
      failures++;
      $display("FAIL after_stall got v=%b sum=%h ovf=%b want 1 04 0",
               out_valid[0], out_sum[0], out_ovf[0]);
    end
    cyc(1'b0, 4'd0, 1'b1);
  endtask

  task automatic test_bubbles();
    do_reset();
    cyc(1'b1, 4'd7, 1'b0);
    checks++;
    if (busy[2] !== 1'b1) begin
      failures++; $display("FAIL bubble_busy got %b want 1", busy[2]);
    end
    cyc(1'b0, 4'hF, 1'b0);
    cyc(1'b0, 4'hF, 1'b0);
    checks++;
    if (busy[2] !== 1'b1 || out_valid[2] !== 1'b0) begin
      failures++;
      $display("FAIL bubble_hold got busy=%b v=%b want 1 0", busy[2], out_valid[2]);
    end
    cyc(1'b1, 4'd2, 1'b0);
    cyc(1'b0, 4'd0, 1'b0);
    cyc(1'b1, 4'd6, 1'b0);
    checks++;
    if (out_valid[2] !== 1'b1 || out_sum[2] !== 8'h0F || out_ovf[2] !== 1'b0) begin
      failures++;
      $display("FAIL bubble_result got v=%b sum=%h ovf=%b want 1 0f 0",
               out_valid[2], out_sum[2], out_ovf[2]);
    end
    cyc(1'b0, 4'd0, 1'b1);
  endtask

  task automatic test_mid_reset();
    do_reset();
    cyc(1'b1, 4'd9, 1'b0);
    cyc(1'b1, 4'd9, 1'b0);
    rst = 1'b1;
    cyc(1'b0, 4'd0, 1'b0);
    rst = 1'b0; #1;
    checks++;
    if (out_valid[0] !== 1'b0 || out_sum[0] !== 8'h00 || out_ovf[0] !== 1'b0 || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got v=%b sum=%h ovf=%b busy=%b want all 0",
               out_valid[0], out_sum[0], out_ovf[0], busy[0]);
    end
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'd1, 1'b0);
    checks++;
    if (out_valid[0] !== 1'b1 || out_sum[0] !== 8'h04 || out_ovf[0] !== 1'b0) begin
      failures++;
      $display("FAIL after_mid_reset got v=%b sum=%h ovf=%b want 1 04 0",
               out_valid[0], out_sum[0], out_ovf[0]);
    end
    cyc(1'b0, 4'd0, 1'b1);
  endtask

  task automatic test_count_one();
    do_reset();
    cyc(1'b1, 4'hC, 1'b0);
    checks++;
    if (out_valid[3] !== 1'b1 || out_sum[3] !== 8'h0C || busy[3] !== 1'b0) begin
      failures++;
      $display("FAIL count_one got v=%b sum=%h busy=%b want 1 0c 0",
               out_valid[3], out_sum[3], busy[3]);
    end
    cyc(1'b1, 4'h3, 1'b1);
    checks++;
    if (out_valid[3] !== 1'b0 || busy[3] !== 1'b0) begin
      failures++;
      $display("FAIL count_one_drain got v=%b busy=%b want 0 0", out_valid[3], busy[3]);
    end
    cyc(1'b1, 4'h3, 1'b0);
    checks++;
    if (out_valid[3] !== 1'b1 || out_sum[3] !== 8'h03 || busy[3] !== 1'b0) begin
      failures++;
      $display("FAIL count_one_next got v=%b sum=%h busy=%b want 1 03 0",
               out_valid[3], out_sum[3], busy[3]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_bubbles();
    test_mid_reset();
    test_count_one();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
